wb_dma_master: RTL

Word-copy DMA engine acting as a Wishbone B3 classic-cycle initiator. It occupies a spare master slot of the Wishbone crossbar, next to the CPU instruction and data masters. It copies a block of 32-bit words from a source address to a destination address through the interconnect, one read followed by one write per word. Software control is a simple start/parameter port, so the block is purely a bus initiator, the counterpart of the BRAM and peripheral responders.

---
 rtl/wb_dma_master.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_dma_master.sv
// Word-copy DMA engine, Wishbone B3 classic-cycle initiator.
// Each word is one read access followed by one write access. All outputs
// are registered. The transfer stops early on a responder error or when
// an access has waited too long for ack.
module wb_dma_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] xfer_cnt_o,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Counter must be able to hold TIMEOUT-1 stalled cycles.
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]       state;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic [TW-1:0]    tmo_q;
  logic [LEN_W-1:0] xfer_next;
  logic             tmo_hit;
  logic             abort;

  // tmo_q counts stalled cycles already spent in this access; the current
  // stalled cycle is the TIMEOUT-th one when tmo_q equals TIMEOUT-1.
  assign tmo_hit   = (TIMEOUT != 0) && (32'(tmo_q) == TIMEOUT - 1);
  // Error has priority over a simultaneous ack.
  assign abort     = wb_err_i || (!wb_ack_i && tmo_hit);
  assign xfer_next = xfer_cnt_o + 1'b1;

  // Control FSM plus registered bus outputs and transfer bookkeeping.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register; the async
  // reset branch releases the bus without waiting for a clock edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state      <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      tmo_q      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      xfer_cnt_o <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            // Word alignment: low address bits are simply masked off.
            src_q      <= src_addr_i & 32'hFFFF_FFFC;
            dst_q      <= dst_addr_i & 32'hFFFF_FFFC;
            len_q      <= len_i;
            err_o      <= 1'b0;
            xfer_cnt_o <= '0;
            tmo_q      <= '0;
            if (len_i == '0) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state    <= S_RD;
              busy_o   <= 1'b1;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_sel_o <= 4'b1111;
              wb_we_o  <= 1'b0;
              wb_adr_o <= src_addr_i & 32'hFFFF_FFFC;
            end
          end
        end

        S_RD, S_WR: begin
          if (abort) begin
            state    <= S_DONE;
            err_o    <= 1'b1;
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
          end else if (wb_ack_i) begin
            tmo_q <= '0;
            if (state == S_RD) begin
              // Read data goes straight into the write-data register and
              // the write access follows with cyc held high.
              state    <= S_WR;
              wb_dat_o <= wb_dat_i;
              wb_we_o  <= 1'b1;
              wb_adr_o <= dst_q;
            end else begin
              xfer_cnt_o <= xfer_next;
              src_q      <= src_q + 32'd4;
              dst_q      <= dst_q + 32'd4;
              if (xfer_next == len_q) begin
                state    <= S_DONE;
                done_o   <= 1'b1;
                busy_o   <= 1'b0;
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                wb_sel_o <= '0;
              end else begin
                state    <= S_RD;
                wb_we_o  <= 1'b0;
                wb_adr_o <= src_q + 32'd4;
              end
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
